// File: rtl/wb_fifo_arbiter.sv
// Round-robin arbiter sharing one wb_fifo Wishbone port between two single-strobe requesters.
// Each accepted request waits in a per-port slot and is replayed as a one-cycle FIFO strobe.
module wb_fifo_arbiter #(
    parameter int DW = 8,
    parameter int EW = 8
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_m0_stb,
    input  logic          i_m0_we,
    input  logic [DW-1:0] i_m0_data,
    output logic [DW-1:0] o_m0_data,
    output logic          o_m0_ack,
    output logic          o_m0_err,
    output logic          o_m0_stall,
    input  logic          i_m1_stb,
    input  logic          i_m1_we,
    input  logic [DW-1:0] i_m1_data,
    output logic [DW-1:0] o_m1_data,
    output logic          o_m1_ack,
    output logic          o_m1_err,
    output logic          o_m1_stall,
    output logic          o_fifo_stb,
    output logic          o_fifo_cyc,
    output logic          o_fifo_we,
    output logic [DW-1:0] o_fifo_data,
    input  logic [DW-1:0] i_fifo_data,
    input  logic          i_fifo_ack,
    output logic [EW-1:0] o_err_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          grant;
    logic          grant_next;
    logic          last_grant;
    logic [1:0]    slot_full;
    logic [1:0]    slot_we;
    logic [DW-1:0] slot_data [2];
    logic [1:0]    ack;
    logic [1:0]    err;
    logic [DW-1:0] rd_data [2];
    logic [EW-1:0] err_count;
    logic [1:0]    req_stb;
    logic [1:0]    req_we;
    logic [DW-1:0] req_data [2];

    assign req_stb     = {i_m1_stb, i_m0_stb};
    assign req_we      = {i_m1_we, i_m0_we};
    assign req_data[0] = i_m0_data;
    assign req_data[1] = i_m1_data;

    // When both slots wait, the port that did not win last time goes next.
    always_comb begin
        state_next = state;
        grant_next = grant;
        case (state)
            IDLE: begin
                if (|slot_full) begin
                    state_next = ISSUE;
                    if (&slot_full) begin
                        grant_next = ~last_grant;
                    end else begin
                        grant_next = slot_full[1];
                    end
                end
            end
            ISSUE:   state_next = WAIT;
            WAIT:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_fifo_stb  = 1'b0;
        o_fifo_cyc  = 1'b0;
        o_fifo_we   = 1'b0;
        o_fifo_data = '0;
        if (state == ISSUE) begin
            o_fifo_stb  = 1'b1;
            o_fifo_cyc  = 1'b1;
            o_fifo_we   = slot_we[grant];
            o_fifo_data = slot_data[grant];
        end
    end

    // The granted slot is always full here, so a new strobe never lands on the slot being retired.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= IDLE;
            grant        <= 1'b0;
            last_grant   <= 1'b1;
            slot_full    <= '0;
            slot_we      <= '0;
            slot_data[0] <= '0;
            slot_data[1] <= '0;
            ack          <= '0;
            err          <= '0;
            rd_data[0]   <= '0;
            rd_data[1]   <= '0;
            err_count    <= '0;
        end else begin
            state <= state_next;
            grant <= grant_next;
            ack   <= '0;
            err   <= '0;
            if (state == WAIT) begin
                slot_full[grant] <= 1'b0;
                last_grant       <= grant;
                if (i_fifo_ack) begin
                    ack[grant] <= 1'b1;
                    if (!slot_we[grant]) begin
                        rd_data[grant] <= i_fifo_data;
                    end
                end else begin
                    err[grant] <= 1'b1;
                    if (err_count != {EW{1'b1}}) begin
                        err_count <= err_count + EW'(1);
                    end
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (req_stb[p] && !slot_full[p]) begin
                    slot_full[p] <= 1'b1;
                    slot_we[p]   <= req_we[p];
                    slot_data[p] <= req_data[p];
                end
            end
        end
    end

    assign o_m0_data   = rd_data[0];
    assign o_m1_data   = rd_data[1];
    assign o_m0_ack    = ack[0];
    assign o_m1_ack    = ack[1];
    assign o_m0_err    = err[0];
    assign o_m1_err    = err[1];
    assign o_m0_stall  = slot_full[0];
    assign o_m1_stall  = slot_full[1];
    assign o_err_count = err_count;

endmodule

// File: tb/tb_wb_fifo_arbiter.sv
// Bench for wb_fifo_arbiter: a 4-deep FIFO responder plus a transaction-timing reference model.
// Directed scenarios come first, then randomized traffic with occasional resets.
module tb_wb_fifo_arbiter;

    localparam int DW = 8;
    localparam int EW = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_stb, m0_we, m1_stb, m1_we;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          m0_ack, m0_err, m0_stall, m1_ack, m1_err, m1_stall;
    logic          fifo_stb, fifo_cyc, fifo_we;
    logic [DW-1:0] fifo_wdata;
    logic [DW-1:0] fifo_rdata = '0;
    logic          fifo_ack = 1'b0;
    logic [EW-1:0] err_count;

    int errors = 0;
    int checks = 0;

    wb_fifo_arbiter #(.DW(DW), .EW(EW)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_data(m0_wdata),
        .o_m0_data(m0_rdata), .o_m0_ack(m0_ack), .o_m0_err(m0_err), .o_m0_stall(m0_stall),
        .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_data(m1_wdata),
        .o_m1_data(m1_rdata), .o_m1_ack(m1_ack), .o_m1_err(m1_err), .o_m1_stall(m1_stall),
        .o_fifo_stb(fifo_stb), .o_fifo_cyc(fifo_cyc), .o_fifo_we(fifo_we),
        .o_fifo_data(fifo_wdata), .i_fifo_data(fifo_rdata), .i_fifo_ack(fifo_ack),
        .o_err_count(err_count)
    );

    always #5 clk = ~clk;

    // Stand-in for wb_fifo: registered ack the cycle after a strobe, none on push-full or pop-empty.
    logic [DW-1:0] fq[$];
    always @(posedge clk) begin
        fifo_ack <= 1'b0;
        if (fifo_stb) begin
            if (fifo_we) begin
                if (fq.size() < DEPTH) begin
                    fq.push_back(fifo_wdata);
                    fifo_ack <= 1'b1;
                end
            end else if (fq.size() > 0) begin
                fifo_rdata <= fq.pop_front();
                fifo_ack   <= 1'b1;
            end
        end
    end

    // Reference model: pending request per port, plus the one operation in flight
    // (decided at d, strobed at d+1, answered at d+3).
    int            cyc = 0;
    bit   [1:0]    mpend = '0;
    bit            mwe [2];
    logic [DW-1:0] mdata [2];
    int            mready [2];
    logic [DW-1:0] rdat [2];
    bit            inflight = 0;
    int            mg = 0;
    int            last_g = 1;
    int            issue_cyc = -1;
    int            resp_cyc = -1;
    bit            resp_ok = 0;
    logic [DW-1:0] resp_rd = '0;
    int            errcnt = 0;
    logic [DW-1:0] exp_q[$];
    bit            prev_stb = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit s0, input bit w0, input logic [DW-1:0] d0,
                                 input bit s1, input bit w1, input logic [DW-1:0] d1,
                                 input bit rst);
        bit [1:0]      exp_ack;
        bit [1:0]      exp_err;
        bit            e0, e1, exp_stb;
        logic [DW-1:0] exp_data;
        exp_ack = '0;
        exp_err = '0;
        if (inflight && cyc == resp_cyc) begin
            inflight  = 0;
            mpend[mg] = 1'b0;
            last_g    = mg;
            if (resp_ok) begin
                exp_ack[mg] = 1'b1;
                if (!mwe[mg]) rdat[mg] = resp_rd;
            end else begin
                exp_err[mg] = 1'b1;
                if (errcnt < (1 << EW) - 1) errcnt++;
            end
        end
        if (!inflight) begin
            e0 = mpend[0] && mready[0] <= cyc;
            e1 = mpend[1] && mready[1] <= cyc;
            if (e0 || e1) begin
                mg        = (e0 && e1) ? 1 - last_g : (e0 ? 0 : 1);
                inflight  = 1;
                issue_cyc = cyc + 1;
                resp_cyc  = cyc + 3;
            end
        end
        exp_stb  = inflight && cyc == issue_cyc;
        exp_data = exp_stb ? mdata[mg] : '0;
        if (exp_stb) begin
            if (mwe[mg]) begin
                resp_ok = exp_q.size() < DEPTH;
                if (resp_ok) exp_q.push_back(mdata[mg]);
            end else begin
                resp_ok = exp_q.size() > 0;
                if (resp_ok) resp_rd = exp_q.pop_front();
            end
        end
        checkOutput("fifo_stb", fifo_stb, exp_stb);
        checkOutput("fifo_cyc", fifo_cyc, exp_stb);
        checkOutput("fifo_we", fifo_we, exp_stb && mwe[mg]);
        checkOutput("fifo_data", fifo_wdata, exp_data);
        checkOutput("no_b2b_stb", prev_stb && fifo_stb, 0);
        checkOutput("m0_ack", m0_ack, exp_ack[0]);
        checkOutput("m1_ack", m1_ack, exp_ack[1]);
        checkOutput("m0_err", m0_err, exp_err[0]);
        checkOutput("m1_err", m1_err, exp_err[1]);
        checkOutput("m0_stall", m0_stall, mpend[0]);
        checkOutput("m1_stall", m1_stall, mpend[1]);
        checkOutput("m0_data", m0_rdata, rdat[0]);
        checkOutput("m1_data", m1_rdata, rdat[1]);
        checkOutput("err_count", err_count, errcnt);
        prev_stb = fifo_stb;

        m0_stb = s0; m0_we = w0; m0_wdata = d0;
        m1_stb = s1; m1_we = w1; m1_wdata = d1;
        reset  = rst;
        if (rst) begin
            mpend    = '0;
            inflight = 0;
            last_g   = 1;
            rdat[0]  = '0;
            rdat[1]  = '0;
            errcnt   = 0;
        end else begin
            if (s0 && !mpend[0]) begin
                mpend[0] = 1'b1; mwe[0] = w0; mdata[0] = d0; mready[0] = cyc + 1;
            end
            if (s1 && !mpend[1]) begin
                mpend[1] = 1'b1; mwe[1] = w1; mdata[1] = d1; mready[1] = cyc + 1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, 0, 0, '0, 0);
    endtask

    initial begin
        rdat[0] = '0; rdat[1] = '0;
        mdata[0] = '0; mdata[1] = '0;
        mwe[0] = 0; mwe[1] = 0;
        mready[0] = 0; mready[1] = 0;
        reset = 1'b1;
        m0_stb = 0; m0_we = 0; m0_wdata = '0;
        m1_stb = 0; m1_we = 0; m1_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        prev_stb = 0;

        // Single push, then drain it so the next pop sees an empty FIFO.
        applyStimulus(1, 1, 8'hA5, 0, 0, '0, 0);
        idle(5);
        applyStimulus(1, 0, '0, 0, 0, '0, 0);
        idle(5);
        // Pop on empty FIFO -> err.
        applyStimulus(0, 0, '0, 1, 0, '0, 0);
        idle(5);
        // Same-cycle push by m0 and pop by m1.
        applyStimulus(1, 1, 8'h11, 1, 0, '0, 0);
        idle(9);
        // Fill the FIFO, push on full, then pop everything plus one extra.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1, 1, DW'(8'h20 + i), 0, 0, '0, 0);
            idle(4);
        end
        applyStimulus(1, 1, 8'h77, 0, 0, '0, 0);
        idle(4);
        for (int i = 0; i < DEPTH + 1; i++) begin
            applyStimulus(0, 0, '0, 1, 0, '0, 0);
            idle(4);
        end
        // Both ports re-strobing continuously: grants alternate.
        for (int i = 0; i < 40; i++) applyStimulus(1, 1, DW'(i), 1, 0, '0, 0);
        idle(6);
        // Repeated pops drive the error counter into saturation.
        for (int i = 0; i < 120; i++) applyStimulus(1, 0, '0, 1, 0, '0, 0);
        idle(6);
        // Reset during WAIT.
        applyStimulus(1, 1, 8'h55, 0, 0, '0, 0);
        idle(2);
        applyStimulus(0, 0, '0, 0, 0, '0, 1);
        idle(6);
        // Randomized traffic with rare resets.
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, DW'($urandom),
                          $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, DW'($urandom),
                          $urandom_range(0, 99) == 0);
        end
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
